fetch_unit: RTL

Instruction-fetch and program-counter sequencer for the RV32I core. It consumes the branch unit's `doBranch` decision together with the resolved target, and keeps the PC register. It drives a request/ready handshake to instruction memory and presents one registered instruction slot to decode. Every branch is resolved in execute, so a taken branch or jump always flushes younger fetched instructions and redirects the PC.

---
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready handshake between the fetch unit and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch/PC sequencer: one outstanding imem request, a registered decode
// slot, a one-entry hold buffer for back-pressure, and execute-stage redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         doBranch,
  input  logic [31:0]  brTarget,
  input  logic         id_stall,
  fetch_unit_if.master imem,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_pc4,
  output logic         misalign
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} fetchState_t;

  fetchState_t state, stateNext;
  logic [31:0] pc, pcNext, reqAddr, tgtAligned;
  logic        reqOut, beat, waiting, accept, slotFree, loadMem, loadHold;
  logic        drop, misalignR;
  logic        vld_p1;
  logic [31:0] instr_p1, pc_p1, holdInstr, holdPc;

  assign tgtAligned = brTarget & ~32'h0000_0003;
  assign slotFree   = !vld_p1 || !id_stall;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    reqOut    = 1'b0;
    beat      = 1'b0;
    waiting   = 1'b0;
    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        reqOut  = 1'b1;
        beat    = imem.imem_ready;
        waiting = !imem.imem_ready;
        if (beat && !drop && !doBranch && !slotFree) stateNext = HOLD;
      end
      HOLD: if (!id_stall || doBranch) stateNext = REQ;
      default: stateNext = IDLE;
    endcase
    // A response is only kept if nothing (redirect or pending drop) kills it.
    accept   = beat && !drop && !doBranch;
    loadMem  = accept && slotFree;
    loadHold = (state == HOLD) && !id_stall && !doBranch;
    pcNext   = pc;
    if (doBranch)    pcNext = tgtAligned;
    else if (accept) pcNext = pc + 32'd4;
  end

  // Control state and the address/PC of the decode slot
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      reqAddr   <= RESET_PC;
      vld_p1    <= 1'b0;
      pc_p1     <= 32'h0;
      misalignR <= 1'b0;
      drop      <= 1'b0;
    end else begin
      pc        <= pcNext;
      misalignR <= doBranch & brTarget[1];
      // The presented address is frozen while a request waits, even across a redirect.
      if (!waiting) reqAddr <= pcNext;
      if (doBranch)  drop <= waiting;
      else if (beat) drop <= 1'b0;
      if (doBranch)                 vld_p1 <= 1'b0;
      else if (loadMem || loadHold) vld_p1 <= 1'b1;
      else if (!id_stall)           vld_p1 <= 1'b0;
      if (loadMem)       pc_p1 <= reqAddr;
      else if (loadHold) pc_p1 <= holdPc;
    end
  end

  always_ff @(posedge clk) begin
    if (loadMem)       instr_p1 <= imem.imem_rdata;
    else if (loadHold) instr_p1 <= holdInstr;
    if (accept && !slotFree) begin
      holdInstr <= imem.imem_rdata;
      holdPc    <= reqAddr;
    end
  end

  assign imem.imem_req  = reqOut;
  assign imem.imem_addr = reqAddr;
  assign if_valid       = vld_p1;
  assign if_instr       = vld_p1 ? instr_p1 : NOP;
  assign if_pc          = pc_p1;
  assign if_pc4         = pc_p1 + 32'd4;
  assign misalign       = misalignR;
endmodule
